// File: rtl/filter_pkg.sv
// Shared constants and state type for the ADC serial path.
// The master receiver and the DAC path use the same definitions.
package filter_pkg;

  localparam int ADC_DATA_W     = 12;
  localparam int ADC_LEAD_ZEROS = 4;
  localparam int ADC_FRAME_LEN  = ADC_LEAD_ZEROS + ADC_DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } adc_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous pin, with one extra flop
// used to produce single-cycle rise/fall pulses in the clk domain.
// All flops reset to 1, which is the idle level of sclk and ss.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the pin through the synchronizer chain, keep the previous level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI slave emulating a 16-bit ADC frame: LEAD_ZEROS zero bits, then a
// DATA_W-bit sample, MSB first. miso changes after each sclk falling edge
// (the master samples on that same falling edge, before the change lands).
//
// Handshake: sample_load is a one-cycle strobe with no back-pressure; the
// word is always accepted. frame_done / frame_abort are one-cycle pulses.
module spi_adc_responder
  import filter_pkg::*;
#(
  parameter int DATA_W      = ADC_DATA_W,
  parameter int LEAD_ZEROS  = ADC_LEAD_ZEROS,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_load,
  output logic              miso,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort,
  output logic [1:0]        state_dbg
);

  localparam int F     = LEAD_ZEROS + DATA_W;
  localparam int CNT_W = $clog2(F + 1);

  logic sclk_fall;
  logic ss_rise;
  logic ss_fall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst),
    .d_i    (sclk),
    .rise_o (),
    .fall_o (sclk_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk    (clk),
    .rst_n  (rst),
    .d_i    (ss),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  adc_state_e        state_q;
  logic [DATA_W-1:0] hold_q;
  logic [F-1:0]      shift_q;
  logic [CNT_W-1:0]  count_q;
  logic              miso_q;
  logic              busy_q;
  logic              done_q;
  logic              abort_q;

  // A load in the same cycle as the ss fall bypasses the hold register.
  logic [DATA_W-1:0] load_word_d;
  logic [F-1:0]      frame_word_d;

  assign load_word_d  = sample_load ? sample_in : hold_q;
  assign frame_word_d = F'(load_word_d);

  // Hold register, FSM, shifter and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      shift_q <= '0;
      count_q <= '0;
      miso_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      if (sample_load) begin
        hold_q <= sample_in;
      end
      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          busy_q <= 1'b0;
          if (ss_fall) begin
            shift_q <= frame_word_d;
            count_q <= '0;
            miso_q  <= frame_word_d[F-1];
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            // Abort takes priority over a coincident sclk fall.
            abort_q <= 1'b1;
            miso_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (sclk_fall) begin
            shift_q <= {shift_q[F-2:0], 1'b0};
            count_q <= count_q + 1'b1;
            if (count_q == CNT_W'(F - 1)) begin
              // Master has just sampled the sample LSB.
              miso_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              miso_q <= shift_q[F-2];
            end
          end
        end
        DONE: begin
          miso_q <= 1'b0;
          busy_q <= 1'b0;
          if (ss_rise) begin
            state_q <= IDLE;
          end
        end
        default: begin
          miso_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign miso        = miso_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: a behavioural SPI master drives ss/sclk and
// collects miso bits; the frame word expected at each ss fall is queued and
// popped by a monitor whenever frame_done pulses.
module tb_spi_adc_responder;

  localparam int DW = 12;
  localparam int LZ = 4;
  localparam int F  = LZ + DW;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          sclk;
  logic          ss;
  logic [DW-1:0] sample_in;
  logic          sample_load;
  logic          miso;
  logic          busy;
  logic          frame_done;
  logic          frame_abort;
  logic [1:0]    state_dbg;

  spi_adc_responder dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .ss          (ss),
    .sample_in   (sample_in),
    .sample_load (sample_load),
    .miso        (miso),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .state_dbg   (state_dbg)
  );

  // Scoreboard state and reference model
  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int abort_cnt   = 0;
  logic [F-1:0]  exp_q[$];
  logic [F-1:0]  rcv_word;
  logic [DW-1:0] model_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every frame_done must match the oldest pending frame word.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (frame_done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got frame %0h expected none", rcv_word);
        end else begin
          check("frame_word", 32'(rcv_word), 32'(exp_q.pop_front()));
        end
      end
      if (frame_abort === 1'b1) abort_cnt++;
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] w);
    sample_in   = w;
    sample_load = 1'b1;
    tick(1);
    sample_load = 1'b0;
    model_hold  = w;
  endtask

  task automatic frame_begin();
    exp_q.push_back({{LZ{1'b0}}, model_hold});
    rcv_word = '0;
    ss = 1'b0;
    tick(8);
  endtask

  // One master clock period: sample miso at the falling edge, then wait.
  task automatic sclk_pulse(input int idx, input int half);
    sclk = 1'b0;
    rcv_word = {rcv_word[F-2:0], miso};
    if (idx < LZ) check("lead_zero", 32'(miso), 32'd0);
    check("busy_in_frame", 32'(busy), 32'd1);
    tick(half);
    sclk = 1'b1;
    tick(half);
  endtask

  task automatic frame_end();
    tick(8);
    ss = 1'b1;
    tick(10);
  endtask

  task automatic full_frame(input int half);
    int d0;
    d0 = done_cnt;
    frame_begin();
    for (int i = 0; i < F; i++) sclk_pulse(i, half);
    frame_end();
    check("done_once", 32'(done_cnt), 32'(d0 + 1));
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int a0;
    int d0;
    rst = 1'b0;
    sclk = 1'b1;
    ss = 1'b1;
    sample_in = '0;
    sample_load = 1'b0;
    model_hold = '0;
    tick(3);
    check("reset_outputs", {28'd0, miso, busy, frame_done, frame_abort}, 32'd0);
    rst = 1'b1;
    tick(5);

    // Basic frame
    load(12'hA5C);
    tick(2);
    full_frame(4);

    // Boundary values
    load(12'h000); tick(2); full_frame(4);
    load(12'hFFF); tick(2); full_frame(4);

    // Abort after 7 falls; hold must survive
    load(12'h3C3);
    tick(2);
    a0 = abort_cnt;
    d0 = done_cnt;
    frame_begin();
    for (int i = 0; i < 7; i++) sclk_pulse(i, 4);
    ss = 1'b1;
    tick(10);
    check("abort_once", 32'(abort_cnt), 32'(a0 + 1));
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    check("abort_miso", 32'({miso, busy}), 32'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    full_frame(4);

    // Reload during a frame
    load(12'h123);
    tick(2);
    frame_begin();
    for (int i = 0; i < F; i++) begin
      sclk_pulse(i, 4);
      if (i == 5) load(12'h456);
    end
    frame_end();
    full_frame(4);

    // Extra sclk edges in DONE are ignored
    load(12'hBEE);
    tick(2);
    frame_begin();
    for (int i = 0; i < F; i++) sclk_pulse(i, 4);
    tick(8);
    for (int i = 0; i < 2; i++) begin
      sclk = 1'b0;
      tick(5);
      check("done_extra_miso", 32'({miso, busy}), 32'd0);
      sclk = 1'b1;
      tick(5);
    end
    ss = 1'b1;
    tick(10);

    // Reset mid-frame
    load(12'h5A5);
    tick(2);
    d0 = done_cnt;
    a0 = abort_cnt;
    frame_begin();
    for (int i = 0; i < 9; i++) sclk_pulse(i, 4);
    rst = 1'b0;
    #1;
    check("reset_mid_outputs", {28'd0, miso, busy, frame_done, frame_abort}, 32'd0);
    exp_q.delete();
    model_hold = '0;
    ss = 1'b1;
    sclk = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(5);
    check("reset_no_flags", 32'(done_cnt + abort_cnt), 32'(d0 + a0));
    full_frame(4);   // hold cleared by reset
    load(12'h7E1); tick(2); full_frame(4);

    // Random words and master clock rates
    for (int n = 0; n < 20; n++) begin
      load(12'($urandom_range(0, 4095)));
      tick($urandom_range(1, 4));
      full_frame($urandom_range(4, 7));
    end

    // Ramp 0..255
    for (int n = 0; n < 256; n++) begin
      load(12'(n));
      tick(1);
      full_frame(4);
    end

    check("pending_frames", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
